// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Round-robin arbiter sharing one async-FIFO write port between
//             NREQ producers. Each grant owns the port for up to BURST
//             accepted beats. FIFO full stalls the owner without revoking the
//             grant. Optional macro FIFO_ARB_PRIO_EN gives producer 0 fixed
//             priority in IDLE without disturbing the rotation among 1..NREQ-1.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  input  logic                      full,
  output logic [NREQ-1:0]           gnt,
  output logic                      wr_rq,
  output logic [WIDTH-1:0]          wdata,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(BURST) + 1;
  localparam logic [OW-1:0] LAST_RST  = OW'(NREQ - 1);
  localparam logic [CW-1:0] BEAT_LAST = CW'(BURST - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [OW-1:0]         last_owner_q, last_owner_d;
  logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [OW-1:0]         pick;
  logic                  owner_req;
  logic [NREQ-1:0]       req_sh;
  logic [NREQ*WIDTH-1:0] data_sh;

  // Rotating search starting one past the last owner; optional fixed priority for producer 0
  always_comb begin
    logic            found;
    logic [NREQ-1:0] probe;
    int              idx;
    pick  = '0;
    found = 1'b0;
    probe = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx   = (int'(last_owner_q) + k) % NREQ;
      probe = req >> idx;
      if (!found && probe[0]) begin
        pick  = OW'(idx);
        found = 1'b1;
      end
    end
`ifdef FIFO_ARB_PRIO_EN
    if (req[0]) begin
      pick = '0;
    end
`else
`endif
  end

  // Owner's request and data, selected by shifting so no wide index is needed
  always_comb begin
    req_sh    = req >> owner_q;
    owner_req = req_sh[0];
    data_sh   = req_data >> (int'(owner_q) * WIDTH);
  end

  // Next-state logic and combinational grant; a beat is accepted on the same edge it is granted
  always_comb begin
    logic exit_burst;
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    gnt          = '0;
    exit_burst   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // One bubble cycle: the choice is registered, no grant here
        if (|req) begin
          state_d    = S_BURST;
          owner_d    = pick;
          beat_cnt_d = '0;
        end
      end
      S_BURST: begin
        if (!owner_req) begin
          exit_burst = 1'b1;
        end else if (!full) begin
          gnt        = NREQ'(1) << owner_q;
          beat_cnt_d = beat_cnt_q + 1'b1;
          exit_burst = (beat_cnt_q == BEAT_LAST);
        end
        if (exit_burst) begin
          state_d = S_IDLE;
`ifdef FIFO_ARB_PRIO_EN
          // Priority grants leave the rotation pointer untouched
          if (owner_q != '0) begin
            last_owner_d = owner_q;
          end
`else
          last_owner_d = owner_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Reset overrides any write immediately
    if (!rst_n) begin
      gnt = '0;
    end
  end

  // Write-port drive: data is zeroed whenever no beat is being written
  always_comb begin
    wr_rq = |gnt;
    wdata = wr_rq ? data_sh[WIDTH-1:0] : '0;
    owner = owner_q;
    busy  = (state_q == S_BURST);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_RST;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule
`default_nettype wire
